// File: rtl/qq_head_if.sv
// User-side and chain-side signal bundle for the quick-queue head stage.
// Handshake: a request transfers in the cycle where req && rdy are both high at the rising edge.
interface qq_head_if #(
    parameter int W   = 8,
    parameter int CAP = 16
);
    localparam int CW = $clog2(CAP + 1);

    logic          enq_req;
    logic [W-1:0]  enq_key;
    logic          enq_rdy;
    logic          deq_req;
    logic          deq_rdy;
    logic [W-1:0]  deq_key;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          enq_o;
    logic          deq_o;
    logic [W-1:0]  data_o;
    logic [W-1:0]  data_i;

    modport slave (
        input  enq_req, enq_key, deq_req, data_i,
        output enq_rdy, deq_rdy, deq_key, count, full, empty, enq_o, deq_o, data_o
    );

    modport master (
        output enq_req, enq_key, deq_req, data_i,
        input  enq_rdy, deq_rdy, deq_key, count, full, empty, enq_o, deq_o, data_o
    );
endinterface

// File: rtl/qq_head.sv
// Quick-queue head: keeps the minimum key in a top register and issues one
// spaced enqueue/dequeue operation at a time into the downstream node chain.
module qq_head #(
    parameter int W       = 8,
    parameter int CAP     = 16,
    parameter int OP_GAP  = 2,
    parameter int RET_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    qq_head_if.slave    bus,
    output logic [1:0]  dbg_state
);
    localparam int CW   = $clog2(CAP + 1);
    localparam int GMAX = (OP_GAP > RET_LAT) ? OP_GAP : RET_LAT;
    localparam int GW   = $clog2(GMAX + 1);

    localparam logic [W-1:0]  MAX_KEY  = '1;
    localparam logic [CW-1:0] CAP_C    = CW'(CAP);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((OP_GAP >= 2) ? (OP_GAP - 2) : 0);
    localparam logic [GW-1:0] RET_LOAD = GW'(RET_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_RET  = 2'd2
    } state_e;

    // With a single-cycle gap there is nothing to wait for after an issue.
    localparam state_e GAP_NEXT = (OP_GAP > 1) ? S_GAP : S_IDLE;

    state_e        state_q, state_d;
    logic [W-1:0]  top_q, top_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] wait_q, wait_d;
    logic [W-1:0]  data_o_q, data_o_d;
    logic          enq_o_q, enq_o_d;
    logic          deq_o_q, deq_o_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    logic idle;
    logic enq_rdy;
    logic deq_rdy;
    logic enq_fire;
    logic deq_fire;

    assign idle     = (state_q == S_IDLE);
    assign deq_rdy  = !rst && idle && !empty_q;
    // A pending dequeue wins; the enqueue stays requested until the next idle slot.
    assign enq_rdy  = !rst && idle && !full_q && !(bus.deq_req && !empty_q);
    assign deq_fire = bus.deq_req && deq_rdy;
    assign enq_fire = bus.enq_req && enq_rdy;

    always_comb begin
        state_d  = state_q;
        top_d    = top_q;
        count_d  = count_q;
        wait_d   = wait_q;
        data_o_d = data_o_q;
        enq_o_d  = 1'b0;
        deq_o_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (deq_fire) begin
                    if (count_q == ONE_C) begin
                        top_d   = MAX_KEY;
                        count_d = '0;
                        state_d = GAP_NEXT;
                        wait_d  = GAP_LOAD;
                    end else begin
                        count_d = count_q - ONE_C;
                        deq_o_d = 1'b1;
                        state_d = S_RET;
                        wait_d  = RET_LOAD;
                    end
                end else if (enq_fire) begin
                    count_d = count_q + ONE_C;
                    state_d = GAP_NEXT;
                    wait_d  = GAP_LOAD;
                    if (count_q == '0) begin
                        top_d = bus.enq_key;
                    end else if (bus.enq_key < top_q) begin
                        data_o_d = top_q;
                        top_d    = bus.enq_key;
                        enq_o_d  = 1'b1;
                    end else begin
                        // Equal keys go downstream so earlier arrivals leave first.
                        data_o_d = bus.enq_key;
                        enq_o_d  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (wait_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - GW'(1);
                end
            end
            S_RET: begin
                if (wait_q == '0) begin
                    top_d   = bus.data_i;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign full_d  = (count_d == CAP_C);
    assign empty_d = (count_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            top_q    <= MAX_KEY;
            count_q  <= '0;
            wait_q   <= '0;
            data_o_q <= '0;
            enq_o_q  <= 1'b0;
            deq_o_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            top_q    <= top_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            data_o_q <= data_o_d;
            enq_o_q  <= enq_o_d;
            deq_o_q  <= deq_o_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign bus.enq_rdy = enq_rdy;
    assign bus.deq_rdy = deq_rdy;
    assign bus.deq_key = top_q;
    assign bus.count   = count_q;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.enq_o   = enq_o_q;
    assign bus.deq_o   = deq_o_q;
    assign bus.data_o  = data_o_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_qq_head.sv
// Bench for qq_head: randomized enqueue/dequeue traffic against a multiset
// model of the whole queue, with a small node-chain model answering deq_o.
module tb_qq_head;
    localparam int W       = 8;
    localparam int CAP     = 16;
    localparam int OP_GAP  = 2;
    localparam int RET_LAT = 2;
    localparam int RET_GAP = (OP_GAP > RET_LAT + 2) ? OP_GAP : RET_LAT + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [W-1:0] model_q[$];
    logic [W-1:0] deq_exp_q[$];
    logic [W-1:0] enq_exp_q[$];
    logic [W-1:0] chain_q[$];

    qq_head_if #(.W(W), .CAP(CAP)) bus ();

    qq_head #(.W(W), .CAP(CAP), .OP_GAP(OP_GAP), .RET_LAT(RET_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int min_idx(input logic [W-1:0] q[$]);
        int m = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] < q[m]) m = i;
        end
        return m;
    endfunction

    // ---------------- node chain model ----------------
    logic [W-1:0] ret_val;
    int           ret_cnt;
    always @(negedge clk) begin
        if (rst) begin
            chain_q.delete();
            ret_cnt    = 0;
            bus.data_i = W'($urandom_range(0, 255));
        end else begin
            if (bus.enq_o) chain_q.push_back(bus.data_o);
            if (bus.deq_o) begin
                if (chain_q.size() == 0) begin
                    chk("chain_nonempty_on_deq", 0, 1);
                    ret_val = '1;
                end else begin
                    int idx;
                    idx     = min_idx(chain_q);
                    ret_val = chain_q[idx];
                    chain_q.delete(idx);
                end
                ret_cnt    = RET_LAT;
                bus.data_i = W'($urandom_range(0, 255));
            end else if (ret_cnt > 0) begin
                ret_cnt--;
                bus.data_i = (ret_cnt == 0) ? ret_val : W'($urandom_range(0, 255));
            end else begin
                bus.data_i = W'($urandom_range(0, 255));
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int           exp_count = 0;
    bit           pend_enq  = 1'b0;
    bit           pend_deq  = 1'b0;
    int           last_acc  = -1000;
    int           need_gap  = 0;
    logic [W-1:0] e;
    bit           ea, da;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_count = 0;
            pend_enq  = 1'b0;
            pend_deq  = 1'b0;
            last_acc  = -1000;
            need_gap  = 0;
            chk("enq_rdy_in_rst", bus.enq_rdy, 0);
            chk("deq_rdy_in_rst", bus.deq_rdy, 0);
        end else begin
            chk("count", bus.count, exp_count);
            chk("full", bus.full, exp_count == CAP);
            chk("empty", bus.empty, exp_count == 0);
            chk("enq_o", bus.enq_o, pend_enq);
            chk("deq_o", bus.deq_o, pend_deq);
            if (exp_count == 0) chk("top_when_empty", bus.deq_key, 255);
            if (bus.enq_o) begin
                if (enq_exp_q.size() == 0) begin
                    chk("data_o_expected", 0, 1);
                end else begin
                    e = enq_exp_q.pop_front();
                    chk("data_o", bus.data_o, e);
                end
            end
            ea = bus.enq_req && bus.enq_rdy;
            da = bus.deq_req && bus.deq_rdy;
            if (ea || da) begin
                chk("accept_gap_ok", (cyc - last_acc) >= need_gap, 1);
                chk("single_accept", ea && da, 0);
                last_acc = cyc;
            end
            if (da) begin
                if (deq_exp_q.size() == 0) begin
                    chk("deq_expected", 0, 1);
                end else begin
                    e = deq_exp_q.pop_front();
                    chk("deq_key", bus.deq_key, e);
                end
            end
            pend_enq = ea && !da && exp_count >= 1;
            pend_deq = da && exp_count >= 2;
            need_gap = pend_deq ? RET_GAP : OP_GAP;
            if (da) exp_count--;
            else if (ea) exp_count++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_acc(input bit is_deq);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (is_deq ? (bus.deq_req && bus.deq_rdy) : (bus.enq_req && bus.enq_rdy)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(is_deq ? "deq_accept_timeout" : "enq_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_enq_model(input logic [W-1:0] key);
        logic [W-1:0] m;
        if (model_q.size() > 0) begin
            m = model_q[min_idx(model_q)];
            enq_exp_q.push_back((key < m) ? m : key);
        end
        model_q.push_back(key);
    endtask

    task automatic push_deq_model();
        int idx;
        idx = min_idx(model_q);
        deq_exp_q.push_back(model_q[idx]);
        model_q.delete(idx);
    endtask

    task automatic do_enq(input logic [W-1:0] key);
        push_enq_model(key);
        bus.enq_req = 1'b1;
        bus.enq_key = key;
        wait_acc(1'b0);
        bus.enq_req = 1'b0;
        bus.enq_key = W'($urandom_range(0, 255));
    endtask

    task automatic do_deq();
        push_deq_model();
        bus.deq_req = 1'b1;
        wait_acc(1'b1);
        bus.deq_req = 1'b0;
    endtask

    task automatic do_both(input logic [W-1:0] key);
        push_deq_model();
        bus.deq_req = 1'b1;
        bus.enq_req = 1'b1;
        bus.enq_key = key;
        wait_acc(1'b1);
        bus.deq_req = 1'b0;
        push_enq_model(key);
        wait_acc(1'b0);
        bus.enq_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dbg_state == 2'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic peek_top(input string name, input logic [W-1:0] exp);
        wait_idle();
        @(negedge clk);
        chk(name, bus.deq_key, exp);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.enq_req = 1'b0;
        bus.deq_req = 1'b0;
        bus.enq_key = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_enq_rdy", bus.enq_rdy, 1);
        chk("rst_deq_rdy", bus.deq_rdy, 0);
        chk("rst_top", bus.deq_key, 255);
        chk("rst_enq_o", bus.enq_o, 0);
        chk("rst_deq_o", bus.deq_o, 0);
        chk("rst_data_o", bus.data_o, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk);
        #1;

        // first key lands in top, smaller key pushes old top, equal key goes downstream
        do_enq(8'h30);
        peek_top("top_after_first", 8'h30);
        do_enq(8'h10);
        peek_top("top_after_smaller", 8'h10);
        do_enq(8'h10);
        peek_top("top_after_equal", 8'h10);
        do_deq();
        peek_top("top_after_deq1", 8'h10);
        do_deq();
        peek_top("top_after_deq2", 8'h30);
        do_deq();

        // fill to capacity with descending keys, then hold a rejected enqueue
        for (int k = 16; k >= 1; k--) do_enq(W'(k));
        bus.enq_req = 1'b1;
        bus.enq_key = 8'h05;
        repeat (6) begin
            @(negedge clk);
            chk("enq_rdy_when_full", bus.enq_rdy, 0);
        end
        @(posedge clk);
        #1;
        bus.enq_req = 1'b0;
        do_deq();
        while (model_q.size() > 3) do_deq();

        // simultaneous requests: dequeue first, enqueue at next idle slot
        do_both(8'h07);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (model_q.size() == 0 || (r < 4 && model_q.size() < CAP)) begin
                do_enq(W'($urandom_range(0, 254)));
            end else if (r < 8) begin
                do_deq();
            end else if (r == 8 && model_q.size() < CAP) begin
                do_both(W'($urandom_range(0, 254)));
            end else begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // reset while waiting for the chain's replacement key
        wait_idle();
        while (model_q.size() < 2) do_enq(W'($urandom_range(0, 254)));
        do_deq();
        rst = 1'b1;
        model_q.delete();
        deq_exp_q.delete();
        enq_exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rret_count", bus.count, 0);
        chk("rret_top", bus.deq_key, 255);
        chk("rret_empty", bus.empty, 1);
        chk("rret_enq_o", bus.enq_o, 0);
        chk("rret_deq_o", bus.deq_o, 0);
        chk("rret_state", dbg_state, 0);
        @(posedge clk);
        #1;
        do_enq(8'h44);
        do_enq(8'h22);
        do_deq();
        do_deq();
        repeat (6) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/qq_head.md
Name: qq_head

Overview:
- Front-end stage of the quick-queue pipeline; sits directly upstream of the first qq_node.
- Accepts user enqueue/dequeue requests over valid/ready handshakes and holds the current minimum key in a local top register.
- Issues one enqueue or dequeue operation at a time into the node chain, spaced so the nodes' BRAM read/modify/write completes.
- Tracks total occupancy and produces the system-level full/empty flags.

Parameters:
- W, 8, key width in bits.
- CAP, 16, total capacity: 1 top register plus all downstream node entries.
- OP_GAP, 2, minimum cycles between successive operations issued to the chain (≥1).
- RET_LAT, 2, cycles from a deq_o pulse to a valid replacement key on data_i (≥1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- enq_req  in  1  user enqueue request
- enq_key  in  W  key to enqueue
- enq_rdy  out  1  enqueue accepted when enq_req && enq_rdy
- deq_req  in  1  user dequeue request
- deq_rdy  out  1  dequeue accepted when deq_req && deq_rdy
- deq_key  out  W  current minimum key; valid when deq_rdy=1
- count  out  $clog2(CAP+1)  number of stored keys
- full  out  1  count==CAP
- empty  out  1  count==0
- enq_o  out  1  one-cycle enqueue strobe to node 0
- deq_o  out  1  one-cycle dequeue strobe to node 0
- data_o  out  W  key pushed to node 0; valid with enq_o
- data_i  in  W  replacement minimum returned from node 0

Behaviour:
- Ordering: smaller key = higher priority. MAX_KEY = all ones marks an empty top.
- Reset: state IDLE, top=MAX_KEY, count=0, enq_o=0, deq_o=0, data_o=0, gap counter=0. Outputs therefore reset to empty=1, full=0, enq_rdy=0 during rst and 1 after, deq_rdy=0.
- Reset mid-operation abandons the operation; the chain shares rst, so no drain is required.
- States:
  - IDLE: accepts operations.
  - GAP: waits OP_GAP-1 cycles after issue, then IDLE. Skipped if OP_GAP=1.
  - RET: waits for data_i.
- deq_rdy = IDLE && !empty.
- enq_rdy = IDLE && !full && !(deq_req && !empty). Dequeue has priority over a simultaneous enqueue; the enqueue is held off, not dropped.
- deq_key = top, combinational from the register.
- Enqueue accepted in cycle t, count==0: top<=enq_key, count<=1. No enq_o. Next state GAP, or IDLE if OP_GAP=1.
- Enqueue accepted in cycle t, count≥1:
  - If enq_key < top: data_o<=top and top<=enq_key.
  - Else (including equal): data_o<=enq_key. Equal keys keep arrival order.
  - enq_o=1 in cycle t+1 only; count<=count+1. Next state GAP.
- Dequeue accepted in cycle t, count==1: top<=MAX_KEY, count<=0. No deq_o. Next state GAP.
- Dequeue accepted in cycle t, count≥2:
  - count<=count-1 at the t edge; deq_o=1 in cycle t+1 only. Next state RET.
  - data_i is sampled in cycle t+1+RET_LAT and loaded into top; then IDLE. The RET wait satisfies the gap requirement provided RET_LAT+1 ≥ OP_GAP.
  - During RET, deq_rdy=enq_rdy=0 and the stale top is never exposed.
- full/empty/count are registered. Full rejects enqueue (enq_rdy=0); empty rejects dequeue (deq_rdy=0). count never wraps.
- enq_o and deq_o are never high in the same cycle.
- Requests are level-sensitive; the user holds enq_key stable while enq_req=1 && enq_rdy=0.

Test Plan:
- Reset, then enqueue 0x30 → next cycle top=0x30, count=1, empty=0, no enq_o. Then enqueue 0x10 → enq_o pulse with data_o=0x30, top=0x10, count=2.
- With top=0x10, enqueue 0x10 → enq_o with data_o=0x10 (new key pushed), top unchanged at 0x10.
- With count=2 and top=0x10: dequeue → deq_key=0x10 at acceptance, deq_o pulses one cycle later. Drive data_i=0x30 RET_LAT cycles after deq_o → top=0x30, count=1. deq_rdy stays 0 during the wait.
- Fill to CAP=16 with keys 16..1 → full=1, enq_rdy=0 while enq_req held, count stays 16. Then dequeue once → full=0.
- Hold enq_req and deq_req together with count=3 → dequeue accepted first, enq_rdy=0 that cycle. Enqueue accepted at the next IDLE. Successive accepts are ≥OP_GAP cycles apart.
- Assert rst during RET → next cycle count=0, top=0xFF, empty=1, deq_o/enq_o=0, state IDLE.
